id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core. It sits directly downstream of the decode-stage control signal generator. Each cycle it captures that block's control outputs together with the decoded operands, register addresses and sign-extended immediate. It also owns load-use hazard detection: it converts a hazard into a one-cycle bubble, and turns an external flush into a bubble as well.

## Interface
- DATA_W, 32, width of PC, operand and immediate fields
- RA_W, 5, register-address width
- CNT_W, 16, width of the bubble performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  global freeze (memory wait); register and counter keep contents
- flush  in  1  squash the instruction currently in ID (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_alusrc, id_regdst, id_memwrite, id_memread, id_memtoreg, id_regwrite  in  1 each  decode-stage control signals
- id_aluop  in  2  decode-stage ALU operation class
- id_pc4, id_rs_data, id_rt_data, id_imm  in  DATA_W each  PC+4, register-file reads, sign-extended immediate
- id_rs, id_rt, id_rd  in  RA_W each  source and destination register numbers
- ex_valid  out  1  EX holds a real instruction
- ex_alusrc, ex_regdst, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite  out  1 each  registered control signals
- ex_aluop  out  2  registered ALU operation class
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered data
- ex_rs, ex_rt  out  RA_W each  registered source numbers, used by forwarding
- ex_wreg  out  RA_W  destination register: id_rd if id_regdst, else id_rt; captured at load
- stall  out  1  load-use stall request to PC and IF/ID (combinational)
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use detect: stall = ex_valid & ex_memread & (ex_wreg != 0) & id_valid & ((ex_wreg == id_rs) | (ex_wreg == id_rt)).
  - The stall output is not gated by hold or flush.
- On each rising clk edge, the first matching action applies:
  - hold = 1: all registers unchanged, including bubble_cnt.
  - flush = 1: bubble.
  - stall = 1: bubble.
  - otherwise, load: ex_valid <= id_valid, all control and data fields <= ID inputs, and ex_wreg from the RegDst mux.
- Bubble:
  - ex_valid, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite, ex_alusrc and ex_regdst all <= 0.
  - ex_aluop <= 2'b00 and ex_wreg <= 0.
  - Data and address fields (pc4, rs_data, rt_data, imm, rs, rt) still load from the ID inputs, so their contents are deterministic.
  - bubble_cnt increments by 1 and saturates at all-ones. It increments only when id_valid = 1 or stall = 1; squashing an empty slot is not counted.
- A load with id_valid = 0 also leaves the stage holding a non-instruction. In that case control is loaded as presented. Decode must present zeros for nop; downstream qualifies with ex_valid.
- Register 0 is never a hazard source. A load with ex_wreg = 0 causes no stall.
- The stall self-clears: after the bubble, ex_memread = 0, so stall drops in the next cycle unless a new hazard arises.

## Timing
- Latency is 1 cycle, ID to EX.
- stall is combinational from the EX registers and the id_rs/id_rt/id_valid inputs. It must settle within the same cycle so that PC and IF/ID can hold on the same edge that inserts the bubble.
- Reset (rst_n low, asynchronous, at any time including mid-stall):
  - every output register is 0, and bubble_cnt = 0;
  - stall therefore reads 0;
  - the first edge after release performs a normal load.
- flush and stall in the same cycle produce a single bubble, and bubble_cnt increments by 1.
- hold with a pending stall: nothing changes. stall stays asserted and the bubble is inserted on the first edge with hold = 0.
- Back-to-back load-use hazards are independent: each lw followed by a dependent use yields exactly one bubble.

## Test plan
- Reset mid-run:
  - Stimulus: load with id_regwrite = 1, id_valid = 1; then pull rst_n low between edges.
  - Required response: all ex_* outputs, stall and bubble_cnt read 0 immediately, without a clock edge.
- Plain pipelining:
  - Stimulus: add presented with id_regdst = 1, id_rd = 7, id_rt = 3, id_rs_data = 0x0000_0010.
  - Required response: next cycle ex_wreg = 7, ex_rs_data = 0x10, ex_aluop = 2'b10, ex_valid = 1, stall = 0.
- Load-use hazard:
  - Stimulus: lw with id_rt = 4, id_memread = 1, id_regdst = 0; next instruction has id_rs = 4.
  - Required response: stall = 1 for exactly one cycle, then a bubble in EX (ex_regwrite = 0, ex_valid = 0), bubble_cnt = 1; on the following edge the dependent instruction loads.
- Register-0 exclusion:
  - Stimulus: lw with id_rt = 0, followed by a user with id_rs = 0.
  - Required response: stall stays 0 and bubble_cnt stays 0.
- Flush with simultaneous stall, then hold:
  - Stimulus: assert flush on a cycle where stall = 1.
  - Required response: one bubble and bubble_cnt + 1.
  - Stimulus: then assert hold for 3 cycles while ID changes.
  - Required response: ex_* and bubble_cnt are frozen throughout.
- Counter saturation:
  - Stimulus: CNT_W = 4; force 20 flushes with id_valid = 1.
  - Required response: bubble_cnt stops at 15 and does not wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and bubble insertion; 1-cycle latency ID->EX.
// Backpressure: hold freezes every register; stall asks PC and IF/ID to hold while a bubble enters EX.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_memwrite,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic              ex_memwrite,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_wreg,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
    } data_t;

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q,  ctrl_d;
    data_t            data_q,  data_d;
    logic [RA_W-1:0]  wreg_q,  wreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             stall_w;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign stall_w = valid_q & ctrl_q.memread & (wreg_q != '0) & id_valid &
                     ((wreg_q == id_rs) | (wreg_q == id_rt));

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        wreg_d  = wreg_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            // Data fields always follow ID so a bubble's contents stay deterministic.
            data_d = '{pc4: id_pc4, rs_data: id_rs_data, rt_data: id_rt_data,
                       imm: id_imm, rs: id_rs, rt: id_rt};
            if (flush || stall_w) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                wreg_d  = '0;
                if ((id_valid || stall_w) && (cnt_q != '1))
                    cnt_d = cnt_q + 1'b1;
            end else begin
                valid_d = id_valid;
                ctrl_d  = '{alusrc: id_alusrc, regdst: id_regdst, memwrite: id_memwrite,
                            memread: id_memread, memtoreg: id_memtoreg,
                            regwrite: id_regwrite, aluop: id_aluop};
                wreg_d  = id_regdst ? id_rd : id_rt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            wreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regdst   = ctrl_q.regdst;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_pc4      = data_q.pc4;
    assign ex_rs_data  = data_q.rs_data;
    assign ex_rt_data  = data_q.rt_data;
    assign ex_imm      = data_q.imm;
    assign ex_rs       = data_q.rs;
    assign ex_rt       = data_q.rt;
    assign ex_wreg     = wreg_q;
    assign stall       = stall_w;
    assign bubble_cnt  = cnt_q;

endmodule
